// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder reusing one full-adder cell LSB-first
// Operands load in parallel, one bit is added per clock, and the result is presented in parallel.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q, busy_q, done_q, cout_q;

   logic             s_d, c_d, last_d;
   logic [WIDTH:0]   sum_ext_d;

   // One full-adder evaluation per RUN cycle; the new bit enters sum from the MSB side.
   assign s_d       = a_q[0] ^ b_q[0] ^ c_q;
   assign c_d       = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
   assign sum_ext_d = {s_d, sum_q};
   assign last_d    = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  c_q     <= cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               c_q   <= c_d;
               sum_q <= sum_ext_d[WIDTH:1];
               cnt_q <= cnt_q + 1'b1;
               if (last_d) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cout_q  <= c_d;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sum       = sum_q;
   assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
// Reference result is plain (WIDTH+1)-bit arithmetic a + b + cin.
module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n, start, cin;
   logic [W-1:0] a, b;
   logic         busy, done, carry_out;
   logic [W-1:0] sum;

   int tests = 0;
   int fails = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One addition: start pulse, optional operand scrambling during RUN, latency and result checks.
   task automatic run_add(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic ci, input bit scramble);
      logic [W:0] exp;
      int k;
      exp = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ci};
      @(negedge clk);
      a = ai; b = bi; cin = ci; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
      k = 0;
      while (k < 40) begin
         if (scramble) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         k++;
         if (done) break;
      end
      check({tag, "_latency"}, k, W);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_result"}, {23'd0, carry_out, sum}, {23'd0, exp});
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_sum_hold"}, {24'd0, sum}, {24'd0, exp[W-1:0]});
   endtask

   initial begin
      int dcnt, last_done, bad_gap, overlap, spur;
      logic [W:0] exp5;

      // Reset with random inputs: outputs clear immediately.
      rst_n = 1'b0; start = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      #1;
      check("reset_outputs", {22'd0, busy, done, carry_out, sum}, 32'd0);
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {22'd0, busy, done, carry_out, sum}, 32'd0);

      run_add("zero", 8'h00, 8'h00, 1'b0, 1'b0);
      run_add("ripple", 8'hFF, 8'h01, 1'b0, 1'b0);
      run_add("midchange", 8'h3C, 8'h0F, 1'b1, 1'b1);

      // Held start: back-to-back additions every W+2 cycles.
      exp5 = 9'h0A5 + 9'h05A + 9'd1;
      @(negedge clk);
      a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
      dcnt = 0; last_done = -1; bad_gap = 0; overlap = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy && done) overlap++;
         if (done) begin
            if (last_done < 0 ? (i != W) : (i - last_done != W + 2)) bad_gap++;
            last_done = i;
            dcnt++;
            check("held_result", {23'd0, carry_out, sum}, {23'd0, exp5});
         end
      end
      start = 1'b0;
      check("held_done_count", dcnt, 3);
      check("held_done_spacing", bad_gap, 0);
      check("held_busy_done_overlap", overlap, 0);
      @(negedge clk);

      // Reset mid-RUN aborts with no done pulse.
      a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_outputs", {22'd0, busy, done, carry_out, sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      spur = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) spur++;
      end
      check("abort_no_done", spur, 0);
      run_add("after_abort", 8'h12, 8'h34, 1'b0, 1'b0);

      // Random operands with scrambling during RUN.
      for (int i = 0; i < 20; i++)
         run_add("random", W'($urandom), W'($urandom), 1'($urandom), 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
